// File: rtl/traffic_pkg.sv
// Shared types, lamp encodings and phase helpers for the junction phase scheduler.
package traffic_pkg;

    localparam logic [2:0] LT_RED = 3'b100;
    localparam logic [2:0] LT_YEL = 3'b010;
    localparam logic [2:0] LT_GRN = 3'b001;

    typedef enum logic [1:0] {MAIN = 2'd0, TURN = 2'd1, SIDE = 2'd2} phase_t;
    typedef enum logic [1:0] {GREEN = 2'd0, YELLOW = 2'd1, ALLRED = 2'd2} state_t;

    // Green lamp pattern packed as {M1, M2, MT, S}.
    function automatic logic [11:0] lamp_map(input phase_t p);
        logic [11:0] m;
        case (p)
            MAIN:    m = {LT_GRN, LT_GRN, LT_RED, LT_RED};
            TURN:    m = {LT_GRN, LT_RED, LT_GRN, LT_RED};
            SIDE:    m = {LT_RED, LT_RED, LT_RED, LT_GRN};
            default: m = {4{LT_RED}};
        endcase
        return m;
    endfunction

    function automatic logic [11:0] yellow_map(input logic [11:0] g);
        logic [11:0] m;
        m = {4{LT_RED}};
        for (int i = 0; i < 4; i++) begin
            if (g[i*3 +: 3] == LT_GRN) m[i*3 +: 3] = LT_YEL;
            else                       m[i*3 +: 3] = LT_RED;
        end
        return m;
    endfunction

    // MAIN has no demand bit, so it is only chosen when neither latched phase is waiting.
    function automatic phase_t next_phase(input phase_t cur, input logic turn_dem,
                                          input logic side_dem);
        phase_t n;
        case (cur)
            MAIN:    n = turn_dem ? TURN : (side_dem ? SIDE : MAIN);
            TURN:    n = side_dem ? SIDE : (turn_dem ? TURN : MAIN);
            SIDE:    n = turn_dem ? TURN : (side_dem ? SIDE : MAIN);
            default: n = MAIN;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/traffic_phase_scheduler_timer.sv
// Tick-gated state timer; restarts from zero on clear and saturates so MAIN can rest forever.
module phase_timer #(
    parameter int TW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          tick,
    input  logic [TW-1:0] limit,
    output logic          expired
);

    logic [TW-1:0] count_r;

    // Count ticks since the last state entry.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count_r <= '0;
        end else if (tick && (count_r != {TW{1'b1}})) begin
            count_r <= count_r + TW'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign expired = tick && (count_r >= (limit - TW'(1)));

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Demand-driven GREEN/YELLOW/ALLRED sequencer for the MAIN, TURN and SIDE phases with
// emergency preempt; all lamp and status outputs come straight from registers.
module traffic_phase_scheduler
    import traffic_pkg::*;
#(
    parameter int TW        = 8,
    parameter int MIN_GREEN = 10,
    parameter int SUB_GREEN = 6,
    parameter int YELLOW_T  = 3,
    parameter int ALLRED_T  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       req_side,
    input  logic       req_turn,
    input  logic       req_ped,
    input  logic       emerg,
    output logic [2:0] light_M1,
    output logic [2:0] light_M2,
    output logic [2:0] light_MT,
    output logic [2:0] light_S,
    output logic       ped_walk,
    output logic [1:0] phase,
    output logic       emerg_active
);

    state_t        state_r, state_s;
    phase_t        phase_r, phase_s, next_r, next_s;
    logic          pend_side_r, pend_turn_r, pend_ped_r, preempt_r;
    logic          preempt_s, walk_s, serve_side_s, serve_turn_s, any_pend_s;
    logic          timer_clear_s, timer_expired_s;
    logic [TW-1:0] timer_limit_s;
    logic [11:0]   lamps_s;

    phase_timer #(.TW(TW)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (timer_clear_s),
        .tick    (tick),
        .limit   (timer_limit_s),
        .expired (timer_expired_s)
    );

    // Select the duration that applies to the state currently being timed.
    always_comb begin
        timer_limit_s = TW'(ALLRED_T);
        case (state_r)
            GREEN: begin
                if (phase_r == MAIN) timer_limit_s = TW'(MIN_GREEN);
                else                 timer_limit_s = TW'(SUB_GREEN);
            end
            YELLOW:  timer_limit_s = TW'(YELLOW_T);
            ALLRED:  timer_limit_s = TW'(ALLRED_T);
            default: timer_limit_s = TW'(ALLRED_T);
        endcase
    end

    // Next state and phase; emergency acts on TURN/SIDE green without waiting for a tick.
    always_comb begin
        state_s    = state_r;
        phase_s    = phase_r;
        any_pend_s = pend_side_r | pend_turn_r | pend_ped_r;
        case (state_r)
            GREEN: begin
                if (phase_r == MAIN) begin
                    if (timer_expired_s && any_pend_s && !emerg) state_s = YELLOW;
                    else                                         state_s = GREEN;
                end else begin
                    if (emerg || timer_expired_s) state_s = YELLOW;
                    else                          state_s = GREEN;
                end
            end
            YELLOW: begin
                if (timer_expired_s) state_s = ALLRED;
                else                 state_s = YELLOW;
            end
            ALLRED: begin
                if (timer_expired_s) begin
                    state_s = GREEN;
                    phase_s = emerg ? MAIN : next_r;
                end else begin
                    state_s = ALLRED;
                end
            end
            default: state_s = ALLRED;
        endcase
        timer_clear_s = (state_s != state_r);
    end

    // Next-phase latch, request clearing, walk lamp, preempt tracking and lamp decode.
    always_comb begin
        next_s = next_r;
        if ((state_r == GREEN) && (state_s == YELLOW)) begin
            if (emerg) next_s = MAIN;
            else       next_s = next_phase(phase_r, pend_turn_r, pend_side_r | pend_ped_r);
        end else if (emerg && (state_r != GREEN)) begin
            next_s = MAIN;
        end else begin
            next_s = next_r;
        end

        serve_side_s = ((state_s == GREEN) && (phase_s == SIDE)) ||
                       ((state_r == GREEN) && (phase_r == SIDE));
        serve_turn_s = ((state_s == GREEN) && (phase_s == TURN)) ||
                       ((state_r == GREEN) && (phase_r == TURN));

        walk_s = 1'b0;
        if ((state_s == GREEN) && (phase_s == SIDE)) begin
            if (state_r == GREEN) walk_s = ped_walk;
            else                  walk_s = pend_ped_r;
        end else begin
            walk_s = 1'b0;
        end

        preempt_s = (emerg | preempt_r) & ~((state_s == GREEN) && (phase_s == MAIN));

        case (state_s)
            GREEN:   lamps_s = lamp_map(phase_s);
            YELLOW:  lamps_s = yellow_map(lamp_map(phase_s));
            ALLRED:  lamps_s = {4{LT_RED}};
            default: lamps_s = {4{LT_RED}};
        endcase
    end

    // State, request latches and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ALLRED;
            phase_r      <= MAIN;
            next_r       <= MAIN;
            pend_side_r  <= 1'b0;
            pend_turn_r  <= 1'b0;
            pend_ped_r   <= 1'b0;
            preempt_r    <= 1'b0;
            {light_M1, light_M2, light_MT, light_S} <= {4{LT_RED}};
            ped_walk     <= 1'b0;
            emerg_active <= 1'b0;
        end else begin
            state_r      <= state_s;
            phase_r      <= phase_s;
            next_r       <= next_s;
            pend_side_r  <= serve_side_s ? 1'b0 : (pend_side_r | req_side);
            pend_ped_r   <= serve_side_s ? 1'b0 : (pend_ped_r | req_ped);
            pend_turn_r  <= serve_turn_s ? 1'b0 : (pend_turn_r | req_turn);
            preempt_r    <= preempt_s;
            {light_M1, light_M2, light_MT, light_S} <= lamps_s;
            ped_walk     <= walk_s;
            emerg_active <= emerg | preempt_s;
        end
    end

    assign phase = phase_r;

endmodule
